ltch_wr_sched: RTL and testbench
================================

Name: ltch_wr_sched

Overview:
- Write scheduler for a latch-based register bank built from `ltch` instances: DEPTH entries, each DW wide, one shared write-data bus, one enable per entry.
- Arbitrates NREQ requesters round-robin.
- Sequences every write as setup → enable pulse → hold, so latch data is stable before the enable rises and after it falls.
- Enables are flop-driven and one-hot, never glitching; sits between the requesting agents and the latch array.

Parameters:
- NREQ, 4, number of requesters (≥2)
- DW, 8, latch data width
- DEPTH, 8, number of latch entries; AW = $clog2(DEPTH) is a derived localparam
- HOLD_CYC, 1, cycles write data is held after enable falls (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_i  in  NREQ  per-requester write request, level
- addr_i  in  NREQ*AW  per-requester entry address; requester k uses bits [k*AW +: AW]
- data_i  in  NREQ*DW  per-requester write data; requester k uses bits [k*DW +: DW]
- ack_o  out  NREQ  one-cycle completion pulse to the granted requester
- err_o  out  1  one-cycle pulse, coincident with ack, when the captured address ≥ DEPTH
- ltch_en_o  out  DEPTH  per-entry latch enable; one-hot or zero
- ltch_data_o  out  DW  shared latch write data
- busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State → IDLE; round-robin pointer → 0.
  - ltch_en_o, ltch_data_o, ack_o, err_o → 0.
  - Reset mid-operation drops ltch_en_o at that same edge. No ack is issued for the aborted write, and the partially written entry is undefined.
- FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE:
  - If any req_i bit is set, grant the first set bit at or after the pointer, wrapping modulo NREQ.
  - Capture the winner's index, addr and data into registers; go to SETUP.
  - If no req_i bit is set, stay in IDLE.
- SETUP (1 cycle):
  - ltch_data_o = captured data; ltch_en_o = 0.
  - Go to PULSE.
- PULSE (1 cycle):
  - ltch_en_o[addr] = 1 if addr < DEPTH, else all zero.
  - ltch_data_o unchanged; go to HOLD.
- HOLD (HOLD_CYC cycles, counter reloaded on entry):
  - ltch_en_o = 0; ltch_data_o unchanged.
  - In the last HOLD cycle: ack_o[winner] = 1, err_o = (addr ≥ DEPTH), pointer ← winner+1 mod NREQ.
  - Then go to IDLE.
- ltch_data_o holds its last value in IDLE; it does not return to 0 except on reset.
- Latency with HOLD_CYC=1: req sampled in IDLE at cycle 0 → en high in cycle 2 → ack in cycle 3.
- Throughput: one write per 3+HOLD_CYC cycles.
- Handshake rules:
  - A requester holds req, addr and data stable until it sees ack, and deasserts req in the cycle after ack.
  - Inputs are captured in IDLE only. Changes to req, addr or data after the grant are ignored; the captured transaction always completes.
  - A req dropped before ack is still acked.
- Simultaneous requests: only one grant per IDLE cycle. Losers wait; no request is lost while it stays asserted.
- Fairness: with all NREQ requesting continuously, grants cycle 0,1,…,NREQ-1,0. Each requester is served within NREQ transactions.
- Pointer wrap: a grant to NREQ-1 sets the pointer to 0.
- Invariants, all required:
  - ltch_en_o is at most one-hot.
  - ltch_en_o is never high in consecutive cycles.
  - ltch_data_o never changes in the cycle before, the cycle of, or the HOLD cycles after an enable.
  - Under PLATFORM_SIM, an assertion checks the one-hot and no-consecutive-enable invariants.

Test Plan:
- Reset then single write: req_i=4'b0010, addr1=3, data1=8'hA5 → ltch_data_o=A5 from cycle 1; ltch_en_o=8'h08 in cycle 2 only; ack_o=4'b0010 in cycle 3; busy_o high cycles 1–3.
- Full contention: req_i=4'b1111 held, each requester dropping req after its ack → grant order 0,1,2,3; four acks spaced 4 cycles apart; ltch_en_o never high in back-to-back cycles.
- Pointer wrap: pointer at 3, req_i=4'b1001 → requester 3 granted first, then 0.
- Out-of-range address: DEPTH=6, addr=7 → ltch_en_o stays 0 throughout; ack and err_o pulse together; next transaction unaffected.
- Mid-operation reset: rst=1 in the PULSE cycle → ltch_en_o=0 and ltch_data_o=0 at that edge; no ack; next request is served from pointer 0.
- HOLD_CYC=3 with input churn: data_i changed from 8'h11 to 8'h22 one cycle after grant → ltch_data_o stays 8'h11 through PULSE and all three HOLD cycles; ack in cycle 5.

Source files
------------

// File: rtl/ltch_wr_sched.sv
// Round-robin write scheduler for a latch bank.
// Each write runs setup, one enable pulse, then hold.
module ltch_wr_sched #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int DEPTH    = 8,
  parameter int HOLD_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*(DEPTH > 1 ? $clog2(DEPTH) : 1)-1:0] addr_i,
  input  logic [NREQ*DW-1:0]   data_i,
  output logic [NREQ-1:0]      ack_o,
  output logic                 err_o,
  output logic [DEPTH-1:0]     ltch_en_o,
  output logic [DW-1:0]        ltch_data_o,
  output logic                 busy_o
);

  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(NREQ);
  localparam int CW = 4;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [DEPTH-1:0] ONE = 1;

  typedef enum logic [1:0] {
    IDLE, SETUP, PULSE, HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0] en_q, en_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            err_q, err_d;

  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;
  logic            oor;
  int              j;

  assign oor = {1'b0, addr_q} >= DEPTH_L;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_vld && req_i[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

  // Next state; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    en_d    = '0;
    ack_d   = '0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          win_d   = gnt_idx;
          addr_d  = addr_i[gnt_idx*AW +: AW];
          dat_d   = data_i[gnt_idx*DW +: DW];
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = PULSE;
        if (!oor) en_d = ONE << addr_q;
      end
      PULSE: begin
        state_d = HOLD;
        cnt_d   = CW'(HOLD_CYC - 1);
        if (HOLD_CYC == 1) begin
          ack_d[win_q] = 1'b1;
          err_d        = oor;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (win_q == PW'(NREQ - 1)) ptr_d = '0;
          else ptr_d = win_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            ack_d[win_q] = 1'b1;
            err_d        = oor;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign ltch_en_o   = en_q;
  assign ltch_data_o = dat_q;
  assign busy_o      = state_q != IDLE;

`ifdef PLATFORM_SIM
  a_onehot: assert property (@(posedge clk) $onehot0(en_q));
  a_no_b2b: assert property (@(posedge clk) disable iff (rst)
    (|en_q) |=> !(|en_q));
`endif

endmodule

// File: tb/tb_ltch_wr_sched.sv
// Directed bench for ltch_wr_sched.
// u0: default params; u1: DEPTH=6, HOLD_CYC=3.
module tb_ltch_wr_sched;

  logic        clk;
  logic        rst;

  logic [3:0]  req0;
  logic [11:0] addr0;
  logic [31:0] data0;
  logic [3:0]  ack0;
  logic        err0;
  logic [7:0]  en0;
  logic [7:0]  ld0;
  logic        busy0;

  logic [3:0]  req1;
  logic [11:0] addr1;
  logic [31:0] data1;
  logic [3:0]  ack1;
  logic        err1;
  logic [5:0]  en1;
  logic [7:0]  ld1;
  logic        busy1;

  int n_vec;
  int n_err;

  ltch_wr_sched #(.NREQ(4), .DW(8), .DEPTH(8), .HOLD_CYC(1)) u0 (
    .clk(clk), .rst(rst), .req_i(req0), .addr_i(addr0),
    .data_i(data0), .ack_o(ack0), .err_o(err0),
    .ltch_en_o(en0), .ltch_data_o(ld0), .busy_o(busy0)
  );

  ltch_wr_sched #(.NREQ(4), .DW(8), .DEPTH(6), .HOLD_CYC(3)) u1 (
    .clk(clk), .rst(rst), .req_i(req1), .addr_i(addr1),
    .data_i(data1), .ack_o(ack1), .err_o(err1),
    .ltch_en_o(en1), .ltch_data_o(ld1), .busy_o(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic txn0(input logic [3:0] r, input int w,
                      input logic [7:0] een, input logic [7:0] edat);
    req0 = r;
    tick;
    chk("u0_setup_data", ld0, edat);
    chk("u0_setup_en", en0, 0);
    tick;
    chk("u0_pulse_en", en0, een);
    tick;
    chk("u0_hold_en", en0, 0);
    chk("u0_ack", ack0, 32'd1 << w);
    chk("u0_err", err0, 0);
    req0[w] = 1'b0;
    tick;
    chk("u0_idle_busy", busy0, 0);
    chk("u0_idle_ack", ack0, 0);
  endtask

  task automatic txn1(input logic [3:0] r, input int w,
                      input logic [5:0] een, input logic [7:0] edat,
                      input logic eerr, input logic churn);
    req1 = r;
    tick;
    if (churn) data1[w*8 +: 8] = 8'h22;
    chk("u1_setup_data", ld1, edat);
    chk("u1_setup_en", en1, 0);
    tick;
    chk("u1_pulse_en", en1, een);
    chk("u1_pulse_data", ld1, edat);
    for (int c = 3; c <= 5; c++) begin
      tick;
      chk("u1_hold_en", en1, 0);
      chk("u1_hold_data", ld1, edat);
      chk("u1_ack", ack1, c == 5 ? (32'd1 << w) : 32'd0);
      chk("u1_err", err1, c == 5 ? 32'(eerr) : 32'd0);
    end
    req1[w] = 1'b0;
    tick;
    chk("u1_idle_busy", busy1, 0);
    chk("u1_idle_ack", ack1, 0);
  endtask

  initial begin
    logic [7:0] prev_en;
    int ph;
    int w;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    req0  = '0;
    addr0 = '0;
    data0 = '0;
    req1  = '0;
    addr1 = '0;
    data1 = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_en", en0, 0);
    chk("rst_data", ld0, 0);
    chk("rst_ack", ack0, 0);
    chk("rst_err", err0, 0);
    chk("rst_busy", busy0, 0);

    // single write from requester 1
    addr0[3 +: 3] = 3'd3;
    data0[8 +: 8] = 8'hA5;
    req0 = 4'b0010;
    tick;
    chk("s_data_c1", ld0, 8'hA5);
    chk("s_en_c1", en0, 0);
    chk("s_busy_c1", busy0, 1);
    tick;
    chk("s_en_c2", en0, 8'h08);
    chk("s_busy_c2", busy0, 1);
    tick;
    chk("s_en_c3", en0, 0);
    chk("s_ack_c3", ack0, 4'b0010);
    chk("s_busy_c3", busy0, 1);
    req0 = 4'b0000;
    tick;
    chk("s_ack_c4", ack0, 0);
    chk("s_busy_c4", busy0, 0);
    chk("s_data_hold", ld0, 8'hA5);

    // full contention from pointer 0
    rst = 1'b1;
    tick;
    rst = 1'b0;
    addr0 = {3'd3, 3'd2, 3'd1, 3'd0};
    data0 = {8'h13, 8'h12, 8'h11, 8'h10};
    req0 = 4'b1111;
    prev_en = '0;
    for (int i = 1; i <= 16; i++) begin
      tick;
      ph = i % 4;
      w  = i / 4;
      chk("c_en", en0, ph == 2 ? (32'd1 << w) : 32'd0);
      chk("c_ack", ack0, ph == 3 ? (32'd1 << w) : 32'd0);
      if (ph == 1) chk("c_data", ld0, 32'h10 + w);
      chk("c_b2b", 32'(|prev_en && |en0), 0);
      prev_en = en0;
      if (ph == 3) req0[w] = 1'b0;
    end

    // pointer wrap: 2 then 3 then 0
    txn0(4'b0100, 2, 8'h04, 8'h12);
    txn0(4'b1001, 3, 8'h08, 8'h13);
    txn0(req0, 0, 8'h01, 8'h10);

    // reset in the pulse cycle
    req0 = 4'b0010;
    tick;
    tick;
    chk("r_pulse_en", en0, 8'h02);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req0 = 4'b0000;
    chk("r_en", en0, 0);
    chk("r_data", ld0, 0);
    chk("r_noack", ack0, 0);
    chk("r_busy", busy0, 0);
    txn0(4'b1001, 0, 8'h01, 8'h10);

    // out-of-range address, DEPTH=6
    addr1[2:0] = 3'd7;
    data1[7:0] = 8'h33;
    txn1(4'b0001, 0, 6'h00, 8'h33, 1'b1, 1'b0);
    addr1[2:0] = 3'd5;
    data1[7:0] = 8'h44;
    txn1(4'b0001, 0, 6'h20, 8'h44, 1'b0, 1'b0);

    // data churn after grant, HOLD_CYC=3
    addr1[2:0] = 3'd2;
    data1[7:0] = 8'h11;
    txn1(4'b0001, 0, 6'h04, 8'h11, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
